// File: rtl/seq_detector_fsm.sv
// Serial bit-sequence detector: pulses output_detected for one cycle when the most
// recent PAT_LEN sampled bits equal PATTERN (PATTERN MSB is the oldest bit).
module seq_detector_fsm #(
  parameter int               PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic input_bit,
  output logic output_detected
);

  // state | meaning
  // S0    | no useful prefix of PATTERN seen
  // Sk    | last k bits equal the first k bits of PATTERN (0 < k < PAT_LEN)
  // SN    | full match, N = PAT_LEN; output_detected is high while here
  localparam int SW = $clog2(PAT_LEN + 1);
  localparam int NS = 1 << SW;
  localparam logic [SW-1:0] S_FULL = SW'(PAT_LEN);

  // Longest prefix of PATTERN that is a suffix of (prefix_k, b); from SN without
  // overlap the history is dropped first, so only b is considered.
  function automatic int f_next(input int k, input logic b);
    logic [PAT_LEN:0] seq;
    int base;
    int n;
    int len;
    logic ok;
    base = (k == PAT_LEN && !OVERLAP) ? 0 : k;
    seq = '0;
    for (int j = 0; j < PAT_LEN; j++)
      if (j < base) seq[j] = PATTERN[PAT_LEN-1-j];
    seq[base] = b;
    n = base + 1;
    len = 0;
    for (int l = 1; l <= PAT_LEN; l++) begin
      if (l <= n) begin
        ok = 1'b1;
        for (int i = 0; i < l; i++)
          if (seq[n-l+i] != PATTERN[PAT_LEN-1-i]) ok = 1'b0;
        if (ok) len = l;
      end
    end
    return len;
  endfunction

  logic [SW-1:0] w_next0 [NS];
  logic [SW-1:0] w_next1 [NS];
  logic [SW-1:0] w_next;
  logic [SW-1:0] r_state;
  logic          r_detected;

  // Encodings above SN are unreachable; they recover to S0.
  for (genvar gk = 0; gk < NS; gk++) begin : g_tbl
    if (gk <= PAT_LEN) begin : g_live
      localparam int N0 = f_next(gk, 1'b0);
      localparam int N1 = f_next(gk, 1'b1);
      assign w_next0[gk] = SW'(N0);
      assign w_next1[gk] = SW'(N1);
    end else begin : g_dead
      assign w_next0[gk] = '0;
      assign w_next1[gk] = '0;
    end
  end

  assign w_next = input_bit ? w_next1[r_state] : w_next0[r_state];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= '0;
      r_detected <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_detected <= (w_next == S_FULL);
    end
  end

  assign output_detected = r_detected;

endmodule

// File: tb/tb_seq_detector_fsm.sv
// Bench for seq_detector_fsm: default (1011, overlap) and a no-overlap instance,
// checked against a last-bits/bit-count model plus hand-computed pulse vectors.
module tb_seq_detector_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic input_bit = 1'b0;
  logic det_ov;
  logic det_no;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Reference: pattern seen in the last 4 bits, with enough bits since reset
  // (overlap) or since reset/last match (no overlap).
  logic [3:0] m_hist = '0;
  int         m_cnt_ov = 0;
  int         m_cnt_no = 0;
  logic       m_exp_ov = 1'b0;
  logic       m_exp_no = 1'b0;

  seq_detector_fsm u_dut_ov (
    .clk(clk), .reset(reset), .input_bit(input_bit), .output_detected(det_ov)
  );

  seq_detector_fsm #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) u_dut_no (
    .clk(clk), .reset(reset), .input_bit(input_bit), .output_detected(det_no)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      m_hist   = '0;
      m_cnt_ov = 0;
      m_cnt_no = 0;
      m_exp_ov = 1'b0;
      m_exp_no = 1'b0;
    end else begin
      m_hist = {m_hist[2:0], input_bit};
      if (m_cnt_ov < 1000) m_cnt_ov++;
      m_cnt_no++;
      m_exp_ov = (m_cnt_ov >= 4) && (m_hist == 4'b1011);
      m_exp_no = (m_cnt_no >= 4) && (m_hist == 4'b1011);
      if (m_exp_no) m_cnt_no = 0;
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("model_ov", det_ov, m_exp_ov);
      check("model_no", det_no, m_exp_no);
    end
  end

  task automatic step(input logic b, input logic r, input logic e_ov, input logic e_no,
                      input string tag);
    reset = r;
    input_bit = b;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_ov"}, det_ov, e_ov);
    check({tag, "_no"}, det_no, e_no);
  endtask

  // Bits and expectations are listed first-bit-first in the MSBs of n-bit fields.
  task automatic run_seq(input logic [15:0] bits, input int n, input logic [15:0] eo,
                         input logic [15:0] en, input string tag);
    for (int i = 0; i < n; i++)
      step(bits[n-1-i], 1'b0, eo[n-1-i], en[n-1-i], tag);
  endtask

  initial begin
    @(negedge clk);
    step(1'b1, 1'b1, 1'b0, 1'b0, "rst_a");
    step(1'b0, 1'b1, 1'b0, 1'b0, "rst_b");
    check_en = 1'b1;
    run_seq(16'b0000, 4, 16'b0000, 16'b0000, "zeros");

    step(1'b0, 1'b1, 1'b0, 1'b0, "rst");
    run_seq(16'b1011, 4, 16'b0001, 16'b0001, "single");
    step(1'b0, 1'b0, 1'b0, 1'b0, "single_after");

    step(1'b0, 1'b1, 1'b0, 1'b0, "rst");
    run_seq(16'b1011011, 7, 16'b0001001, 16'b0001000, "overlap");

    step(1'b0, 1'b1, 1'b0, 1'b0, "rst");
    run_seq(16'b101011, 6, 16'b000001, 16'b000001, "nearmiss");

    step(1'b0, 1'b1, 1'b0, 1'b0, "rst");
    run_seq(16'b11011, 5, 16'b00001, 16'b00001, "fallback");

    step(1'b0, 1'b1, 1'b0, 1'b0, "rst");
    run_seq(16'b101, 3, 16'b000, 16'b000, "mid_head");
    step(1'b1, 1'b1, 1'b0, 1'b0, "mid_rst");
    step(1'b1, 1'b0, 1'b0, 1'b0, "mid_first");
    run_seq(16'b011, 3, 16'b001, 16'b001, "mid_tail");

    step(1'b0, 1'b1, 1'b0, 1'b0, "rst");
    for (int i = 0; i < 100; i++) begin
      reset = 1'b0;
      input_bit = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
